// File: rtl/mem_dump_pkg.sv
// mem_dump_pkg: shared definitions for the mem_dump core and the memories it reads.
// Optional feature: MEM_DUMP_CSUM_EN adds the checksum state.
package mem_dump_pkg;

    localparam int unsigned DEF_ADDR_BITS = 10;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND,
`ifdef MEM_DUMP_CSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

endpackage

// File: rtl/mem_dump_if.sv
// mem_dump_if: byte-memory read port plus valid/ready byte stream.
// The master side is the dump core; the slave side is memory + sink.
interface mem_dump_if
    import mem_dump_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS
);
    logic                 mem_re;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [7:0]           mem_rdata;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output mem_re, mem_addr, out_data, out_valid,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_re, mem_addr, out_data, out_valid,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/mem_dump.sv
// mem_dump: reads len bytes starting at base_addr from an external byte memory
// and streams them out over a valid/ready port, one byte per three cycles.
// Define MEM_DUMP_CSUM_EN to append the two's complement of the byte sum.
module mem_dump
    import mem_dump_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DEF_ADDR_BITS,
    parameter int unsigned LEN_BITS  = ADDR_BITS + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [LEN_BITS-1:0]  len,
    output logic                 busy,
    output logic                 done,
    mem_dump_if.master           bus
);
    state_t               state_q, state_d;
    state_t               data_end;
    logic [ADDR_BITS-1:0] addr_q, last_addr_q;
    logic [LEN_BITS-1:0]  cnt_q;
    logic [7:0]           out_data_q;
    logic                 done_q;
    logic                 xfer, last_byte;
`ifdef MEM_DUMP_CSUM_EN
    logic [7:0]           sum_q, sum_next;
`endif

    // Handshake qualifiers and the state that follows the last data byte
    always_comb begin
        xfer      = (state_q == SEND) && bus.out_ready;
        last_byte = (cnt_q == LEN_BITS'(1));
`ifdef MEM_DUMP_CSUM_EN
        data_end  = CSUM;
        sum_next  = sum_q + out_data_q;
`else
        data_end  = DONE;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state and output decode; mem_addr shows the live address only in READ
    always_comb begin
        state_d       = state_q;
        busy          = (state_q != IDLE);
        done          = done_q;
        bus.mem_re    = (state_q == READ);
        bus.mem_addr  = (state_q == READ) ? addr_q : last_addr_q;
        bus.out_valid = (state_q == SEND);
        bus.out_data  = out_data_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = (len != '0) ? READ : data_end;
            end
            READ: state_d = WAIT;
            WAIT: state_d = SEND;
            SEND: begin
                if (xfer) state_d = last_byte ? data_end : READ;
            end
`ifdef MEM_DUMP_CSUM_EN
            CSUM: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: address/count capture and stepping, data register, done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            last_addr_q <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
`ifdef MEM_DUMP_CSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            done_q <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q <= base_addr;
                        cnt_q  <= len;
`ifdef MEM_DUMP_CSUM_EN
                        sum_q  <= '0;
                        if (len == '0) out_data_q <= '0;
`endif
                    end
                end
                READ: last_addr_q <= addr_q;
                WAIT: out_data_q  <= bus.mem_rdata;
                SEND: begin
                    if (xfer) begin
                        addr_q <= addr_q + ADDR_BITS'(1);
                        cnt_q  <= cnt_q - LEN_BITS'(1);
`ifdef MEM_DUMP_CSUM_EN
                        sum_q  <= sum_next;
                        if (last_byte) out_data_q <= 8'd0 - sum_next;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump.sv
// tb_mem_dump: directed bench for mem_dump with a byte-queue reference model.
// Honours MEM_DUMP_CSUM_EN when the build defines it.
module tb_mem_dump;
    localparam int unsigned AB = 10;
    localparam int unsigned LB = AB + 1;
`ifdef MEM_DUMP_CSUM_EN
    localparam int unsigned CS = 1;
`else
    localparam int unsigned CS = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AB-1:0] base_addr = '0;
    logic [LB-1:0] len = '0;
    logic          busy, done;

    mem_dump_if #(.ADDR_BITS(AB)) bus ();

    mem_dump #(.ADDR_BITS(AB), .LEN_BITS(LB)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [1 << AB];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    int         got_cyc [$];
    int         vectors = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         start_cyc = 0;

    // Byte memory with one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: the dump must produce mem[(base+i) mod 2^AB] for i < n, then the checksum
    task automatic run_dump(input logic [AB-1:0] b, input int unsigned n);
        logic [7:0] sum;
        int unsigned a;
        sum = 8'd0;
        for (int unsigned i = 0; i < n; i++) begin
            a = (int'(b) + i) % (1 << AB);
            exp_q.push_back(mem[a]);
            sum = sum + mem[a];
        end
        if (CS != 0) exp_q.push_back(~sum + 8'd1);
        base_addr = b;
        len       = LB'(n);
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int target, input int unsigned bound);
        for (int unsigned i = 0; i < bound && done_cnt < target; i++) tick();
        check(name, done_cnt, target);
    endtask

    task automatic clear_log();
        got_q.delete();
        got_cyc.delete();
    endtask

    // Compare process: every visible byte must match the head of the model queue
    always @(negedge clk) begin
        if (rst) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", bus.out_valid, 0);
                end else begin
                    check("out_data", bus.out_data, exp_q[0]);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        got_q.push_back(bus.out_data);
                        got_cyc.push_back(cyc);
                    end
                end
            end
            check("mem_re_vs_valid", bus.mem_re & bus.out_valid, 0);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_drained", exp_q.size(), 0);
            end
        end
    end

    initial begin
        int d0;
        logic [7:0] seq_a [4];
        logic [7:0] seq_w [4];
        seq_a[0] = 8'h11; seq_a[1] = 8'h22; seq_a[2] = 8'h33; seq_a[3] = 8'h44;
        seq_w[0] = 8'hA1; seq_w[1] = 8'hA2; seq_w[2] = 8'hA3; seq_w[3] = 8'hA4;

        for (int unsigned i = 0; i < (1 << AB); i++) mem[i] = 8'((i * 37 + 5) % 256);
        for (int unsigned i = 0; i < 4; i++) mem[16 + i] = seq_a[i];
        mem[10'h3FE] = 8'hA1;
        mem[10'h3FF] = 8'hA2;
        mem[10'h000] = 8'hA3;
        mem[10'h001] = 8'hA4;
        bus.out_ready = 1'b1;

        // Reset values
        #2 rst = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_mem_re", bus.mem_re, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Basic dump, with a start pulse during the dump that must be ignored
        clear_log();
        d0 = done_cnt;
        run_dump(10'h010, 4);
        check("a_busy", busy, 1);
        tick();
        tick();
        base_addr = 10'h100;
        len       = LB'(2);
        start     = 1'b1;
        tick();
        start = 1'b0;
        wait_done("a_done", d0 + 1, 60);
        check("a_count", got_q.size(), 4 + CS);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("a_byte", got_q[i], seq_a[i]);
        for (int i = 0; i < 3 && i + 1 < got_cyc.size(); i++)
            check("a_spacing", got_cyc[i + 1] - got_cyc[i], 3);
`ifdef MEM_DUMP_CSUM_EN
        if (got_q.size() > 4) check("a_csum", got_q[4], 8'h56);
`endif
        tick();
        check("a_busy_after", busy, 0);
        repeat (5) tick();
        check("a_one_done", done_cnt, d0 + 1);

        // Back-pressure on the second byte
        clear_log();
        d0 = done_cnt;
        run_dump(10'h010, 4);
        for (int i = 0; i < 20 && got_q.size() < 1; i++) tick();
        check("b_first", got_q.size(), 1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10 && !bus.out_valid; i++) tick();
        repeat (5) begin
            @(negedge clk);
            check("b_hold_valid", bus.out_valid, 1);
            check("b_hold_data", bus.out_data, 8'h22);
        end
        tick();
        bus.out_ready = 1'b1;
        wait_done("b_done", d0 + 1, 60);
        check("b_count", got_q.size(), 4 + CS);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("b_byte", got_q[i], seq_a[i]);

        // Address wrap
        clear_log();
        d0 = done_cnt;
        run_dump(10'h3FE, 4);
        wait_done("c_done", d0 + 1, 60);
        check("c_count", got_q.size(), 4 + CS);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("c_byte", got_q[i], seq_w[i]);

        // Zero length
        clear_log();
        d0 = done_cnt;
        run_dump(10'h020, 0);
        wait_done("d_done", d0 + 1, 20);
        check("d_count", got_q.size(), CS);
`ifdef MEM_DUMP_CSUM_EN
        if (got_q.size() > 0) check("d_csum", got_q[0], 8'h00);
`else
        check("d_latency", done_cyc - start_cyc, 2);
`endif

        // Reset mid-dump, then a fresh dump
        clear_log();
        d0 = done_cnt;
        run_dump(10'h010, 4);
        for (int i = 0; i < 30 && got_q.size() < 2; i++) tick();
        check("e_two_bytes", got_q.size(), 2);
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        check("e_rst_out_valid", bus.out_valid, 0);
        check("e_rst_out_data", bus.out_data, 0);
        check("e_rst_mem_re", bus.mem_re, 0);
        check("e_rst_mem_addr", bus.mem_addr, 0);
        check("e_rst_busy", busy, 0);
        check("e_rst_done", done, 0);
        tick();
        rst = 1'b1;
        repeat (10) tick();
        check("e_no_done", done_cnt, d0);
        clear_log();
        run_dump(10'h010, 4);
        wait_done("e_done", d0 + 1, 60);
        check("e_count", got_q.size(), 4 + CS);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("e_byte", got_q[i], seq_a[i]);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
